inequality_sweep_ctrl: RTL and testbench

Self-test sequencer for the 4-bit Inequality evaluator. On START it drives every input code 0..2^WIDTH-1 onto the evaluator's NUM input in ascending order. It waits a programmable settle time per code, then captures the evaluator's OUTS-bit result into a truth-table register and compares it against an expected table. It sits beside the combinational evaluator and owns its NUM input during a sweep.

---
 rtl/inequality_sweep_ctrl.sv | 111 +++++++++++
 tb/tb_inequality_sweep_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inequality_sweep_ctrl.sv
// inequality_sweep_ctrl: sweeps every evaluator input code, captures its truth table and compares it with an expected table.
// Ports: clk/rst_n clock and async active-low reset; start/abort control; exp expected table (latched at start);
// out_in evaluator result; num code driven to evaluator; busy sweep running; done completion pulse;
// tt captured table (tt[n*OUTS+b] = out_in[b] at num=n); match all codes matched; fail_valid/first_fail lowest mismatching code.
module inequality_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int OUTS   = 3,
  parameter int SETTLE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [OUTS*(1<<WIDTH)-1:0]    exp,
  input  logic [OUTS-1:0]               out_in,
  output logic [WIDTH-1:0]              num,
  output logic                          busy,
  output logic                          done,
  output logic [OUTS*(1<<WIDTH)-1:0]    tt,
  output logic                          match,
  output logic                          fail_valid,
  output logic [WIDTH-1:0]              first_fail
);
  localparam int N  = 1 << WIDTH;
  localparam int TW = OUTS * N;
  localparam int CW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   wcnt, wcnt_n;
  logic [TW-1:0]   exp_q, exp_n, tt_n;
  logic [WIDTH-1:0] num_n, first_fail_n;
  logic            busy_n, done_n, match_n, fail_valid_n;
  logic [OUTS-1:0] exp_slice;
  logic            mis, last, sample;
  assign exp_slice = exp_q[num*OUTS +: OUTS];
  assign mis       = out_in != exp_slice;
  assign last      = num == WIDTH'(N - 1);
  assign sample    = wcnt == CW'(SETTLE);
  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    exp_n        = exp_q;
    tt_n         = tt;
    num_n        = num;
    first_fail_n = first_fail;
    busy_n       = busy;
    done_n       = 1'b0;
    match_n      = match;
    fail_valid_n = fail_valid;
    if (state == IDLE) begin
      if (start && !abort) begin
        state_n      = RUN;
        busy_n       = 1'b1;
        num_n        = '0;
        wcnt_n       = '0;
        tt_n         = '0;
        match_n      = 1'b0;
        fail_valid_n = 1'b0;
        first_fail_n = '0;
        exp_n        = exp;
      end
    end else if (abort) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      num_n   = '0;
    end else if (!sample) begin
      wcnt_n = wcnt + 1'b1;
    end else begin
      tt_n[num*OUTS +: OUTS] = out_in;
      if (mis && !fail_valid) begin
        fail_valid_n = 1'b1;
        first_fail_n = num;
      end
      if (last) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        num_n   = '0;
        match_n = !(fail_valid || mis);
      end else begin
        num_n  = num + 1'b1;
        wcnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      exp_q      <= '0;
      tt         <= '0;
      num        <= '0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      exp_q      <= exp_n;
      tt         <= tt_n;
      num        <= num_n;
      first_fail <= first_fail_n;
      busy       <= busy_n;
      done       <= done_n;
      match      <= match_n;
      fail_valid <= fail_valid_n;
    end
  end
endmodule

// File: tb/tb_inequality_sweep_ctrl.sv
// tb_inequality_sweep_ctrl: checks the sweep controller against a loopback evaluator model.
module tb_inequality_sweep_ctrl;
  logic        clk = 0, rst_n = 1, start = 0, abort = 0;
  logic [47:0] exp_in = '0, tt;
  logic [2:0]  out_in;
  logic [3:0]  num, first_fail;
  logic        busy, done, match, fail_valid;
  logic        start6 = 0;
  logic [47:0] tt6;
  logic [2:0]  out6;
  logic [3:0]  num6, ff6;
  logic        busy6, done6, match6, fv6;
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign out_in = {3{num >= 4'd8}};
  assign out6   = {3{num6 >= 4'd8}};

  inequality_sweep_ctrl #(.WIDTH(4), .OUTS(3), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp(exp_in), .out_in(out_in),
    .num(num), .busy(busy), .done(done), .tt(tt), .match(match), .fail_valid(fail_valid), .first_fail(first_fail));

  inequality_sweep_ctrl #(.WIDTH(4), .OUTS(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start6), .abort(1'b0), .exp(48'hFFFFFF000000), .out_in(out6),
    .num(num6), .busy(busy6), .done(done6), .tt(tt6), .match(match6), .fail_valid(fv6), .first_fail(ff6));

  typedef struct {
    logic [47:0] exp_v;
    int          abort_at, rs_a, rs_b, done_at;
    logic [47:0] tt_e;
    logic        match_e, fv_e;
    logic [3:0]  ff_e;
  } vec_t;
  typedef struct packed {
    logic [47:0] tt_e;
    logic        match_e, fv_e;
    logic [3:0]  ff_e;
  } res_t;
  vec_t tbl[4];
  res_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    res_t r;
    int   stop;
    stop   = v.abort_at > 0 ? v.abort_at : v.done_at;
    exp_in = v.exp_v;
    start  = 1;
    tick();
    start  = 0;
    chk("busy_e0", busy, 1);
    chk("num_e0", num, 0);
    if (v.done_at > 0) sb.push_back('{v.tt_e, v.match_e, v.fv_e, v.ff_e});
    exp_in = ~v.exp_v;
    for (int k = 1; k <= 60; k++) begin
      start = (k == v.rs_a) || (k == v.rs_b);
      abort = (k == v.abort_at);
      tick();
      start = 0;
      abort = 0;
      chk($sformatf("done_k%0d", k), done, k == v.done_at);
      chk($sformatf("busy_k%0d", k), busy, k < stop);
      chk($sformatf("num_k%0d", k), num, k < stop ? k / 3 : 0);
      if (done) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          r = sb.pop_front();
          chk("tt", tt, r.tt_e);
          chk("match", match, r.match_e);
          chk("fail_valid", fail_valid, r.fv_e);
          chk("first_fail", first_fail, r.ff_e);
        end
      end
      if (k == v.abort_at) begin
        chk("abort_match", match, 0);
        chk("abort_tt", tt, v.tt_e);
        chk("abort_fv", fail_valid, v.fv_e);
      end
    end
  endtask

  initial begin
    logic [47:0] bad_exp;
    bad_exp = 48'hFFFFFF000000;
    bad_exp[15] = ~bad_exp[15];
    bad_exp[27] = ~bad_exp[27];
    tbl[0] = '{48'hFFFFFF000000, 0, 0, 0, 48, 48'hFFFFFF000000, 1'b1, 1'b0, 4'd0};
    tbl[1] = '{bad_exp,          0, 0, 0, 48, 48'hFFFFFF000000, 1'b0, 1'b1, 4'd5};
    tbl[2] = '{48'hFFFFFF000000, 10, 0, 0, 0, 48'h0,            1'b0, 1'b0, 4'd0};
    tbl[3] = '{48'hFFFFFF000000, 0, 7, 30, 48, 48'hFFFFFF000000, 1'b1, 1'b0, 4'd0};

    #12 rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    tick();
    rst_n = 1;
    repeat (5) tick();
    chk("rst_num", num, 0);
    chk("rst_busy2", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tt", tt, 0);
    chk("rst_match", match, 0);
    chk("rst_fv", fail_valid, 0);
    chk("rst_ff", first_fail, 0);

    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    chk("start_abort_busy", busy, 0);
    tick();
    chk("start_abort_done", done, 0);

    foreach (tbl[i]) run(tbl[i]);
    chk("sb_drained", sb.size(), 0);

    exp_in = 48'hFFFFFF000000;
    start  = 1;
    tick();
    start  = 0;
    repeat (20) tick();
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_num", num, 0);
    chk("arst_tt", tt, 0);
    chk("arst_ff", first_fail, 0);
    tick();
    rst_n = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("arst_nodone", done, 0);
    end

    start6 = 1;
    tick();
    start6 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("s0_num_k%0d", k), num6, k < 16 ? k : 0);
      chk($sformatf("s0_done_k%0d", k), done6, k == 16);
      if (k == 16) begin
        chk("s0_match", match6, 1);
        chk("s0_tt", tt6, 48'hFFFFFF000000);
        chk("s0_fv", fv6, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
